// File: rtl/fft_bf_scheduler.sv
// Address/control sequencer for an in-place radix-2 DIT FFT: bit-reversed load,
// stage-by-stage butterfly issue with delayed write-back, natural-order unload.
module fft_bf_scheduler #(
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 2
) (
  input  logic             clock,
  input  logic             n_rst,
  input  logic             readyin,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr,
  output logic             bf_valid,
  output logic [LOG2N-1:0] rd_a,
  output logic [LOG2N-1:0] rd_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wb_en,
  output logic [LOG2N-1:0] wb_a,
  output logic [LOG2N-1:0] wb_b,
  output logic             out_valid,
  output logic [LOG2N-1:0] out_addr,
  output logic             busy,
  output logic             done,
  output logic [2:0]       o_dbg_state
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
  localparam logic [LOG2N-2:0] LAST_K     = (LOG2N-1)'(N / 2 - 1);
  localparam logic [3:0]       LAST_STAGE = 4'(LOG2N - 1);
  localparam logic [2:0]       LAST_DRAIN = 3'(BF_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMP, S_DRAIN, S_UNLOAD, S_DONE
  } state_t;

  typedef struct packed {
    logic             v;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wb_t;

  state_t           r_state;
  logic             r_rin0;
  logic             r_rin1;
  logic [LOG2N-1:0] r_ld_cnt;
  logic [LOG2N-1:0] r_out_cnt;
  logic [LOG2N-2:0] r_k;
  logic [3:0]       r_stage;
  logic [2:0]       r_drain;
  wb_t              r_pipe [BF_LAT];

  // readyin is a level strobe with no backpressure: each registered rising
  // edge (w_ev) is exactly one transfer, accepted only in LOAD and UNLOAD.
  logic             w_ev;
  logic [LOG2N-1:0] w_k_ext;
  logic [LOG2N-1:0] w_half;
  logic [LOG2N-1:0] w_grp;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_rd_a;
  logic [LOG2N-1:0] w_rd_b;
  logic [3:0]       w_tw_sh;
  logic [LOG2N-1:0] w_tw_full;
  wb_t              w_issue;

  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  assign w_ev = r_rin0 & ~r_rin1;

  // Butterfly k of stage s pairs addresses half apart inside group k>>s.
  assign w_k_ext   = {1'b0, r_k};
  assign w_half    = LOG2N'(1) << r_stage;
  assign w_grp     = w_k_ext >> r_stage;
  assign w_pos     = w_k_ext & (w_half - LOG2N'(1));
  assign w_rd_a    = (w_grp << (r_stage + 4'd1)) | w_pos;
  assign w_rd_b    = w_rd_a + w_half;
  assign w_tw_sh   = 4'(LOG2N - 1) - r_stage;
  assign w_tw_full = w_pos << w_tw_sh;

  assign wr_en     = (r_state == S_LOAD) & w_ev;
  assign wr_addr   = wr_en ? f_bitrev(r_ld_cnt) : '0;
  assign bf_valid  = (r_state == S_COMP);
  assign rd_a      = bf_valid ? w_rd_a : '0;
  assign rd_b      = bf_valid ? w_rd_b : '0;
  assign tw_idx    = bf_valid ? w_tw_full[LOG2N-2:0] : '0;
  assign out_valid = (r_state == S_UNLOAD) & w_ev;
  assign out_addr  = out_valid ? r_out_cnt : '0;
  assign busy      = (r_state == S_COMP) | (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign o_dbg_state = r_state;

  assign w_issue = {bf_valid, rd_a, rd_b};
  assign wb_en   = r_pipe[BF_LAT-1].v;
  assign wb_a    = r_pipe[BF_LAT-1].a;
  assign wb_b    = r_pipe[BF_LAT-1].b;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < BF_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_issue;
      for (int i = 1; i < BF_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_rin0    <= 1'b0;
      r_rin1    <= 1'b0;
      r_ld_cnt  <= '0;
      r_out_cnt <= '0;
      r_k       <= '0;
      r_stage   <= '0;
      r_drain   <= '0;
    end else begin
      r_rin0 <= readyin;
      r_rin1 <= r_rin0;
      case (r_state)
        S_IDLE: begin
          r_ld_cnt <= '0;
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          if (w_ev) begin
            if (r_ld_cnt == LAST_IDX) begin
              r_ld_cnt <= '0;
              r_k      <= '0;
              r_stage  <= '0;
              r_state  <= S_COMP;
            end else begin
              r_ld_cnt <= r_ld_cnt + 1'b1;
            end
          end
        end
        S_COMP: begin
          if (r_k == LAST_K) begin
            r_k     <= '0;
            r_drain <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          // Hold off the next stage until the last write-back has landed.
          if (r_drain == LAST_DRAIN) begin
            r_drain <= '0;
            if (r_stage == LAST_STAGE) begin
              r_stage   <= '0;
              r_out_cnt <= '0;
              r_state   <= S_UNLOAD;
            end else begin
              r_stage <= r_stage + 4'd1;
              r_state <= S_COMP;
            end
          end else begin
            r_drain <= r_drain + 3'd1;
          end
        end
        S_UNLOAD: begin
          if (w_ev) begin
            if (r_out_cnt == LAST_IDX) begin
              r_out_cnt <= '0;
              r_state   <= S_DONE;
            end else begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Bench for fft_bf_scheduler: two instances (BF_LAT 2 and 4) driven by the same
// strobe/reset stream and checked every cycle against a phase-level model.
module tb_fft_bf_scheduler;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int HN    = N / 2;
  localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_UNLOAD = 3, P_DONE = 4;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic n_rst   = 1'b0;
  logic readyin = 1'b0;
  always #5 clock = ~clock;

  wire [1:0]            o_wr_en, o_bf_valid, o_wb_en, o_out_valid, o_busy, o_done;
  wire [1:0][LOG2N-1:0] o_wr_addr, o_rd_a, o_rd_b, o_wb_a, o_wb_b, o_out_addr;
  wire [1:0][LOG2N-2:0] o_tw;
  wire [1:0][2:0]       o_dbg;

  fft_bf_scheduler #(.LOG2N(LOG2N), .BF_LAT(2)) dut0 (
    .clock(clock), .n_rst(n_rst), .readyin(readyin),
    .wr_en(o_wr_en[0]), .wr_addr(o_wr_addr[0]),
    .bf_valid(o_bf_valid[0]), .rd_a(o_rd_a[0]), .rd_b(o_rd_b[0]), .tw_idx(o_tw[0]),
    .wb_en(o_wb_en[0]), .wb_a(o_wb_a[0]), .wb_b(o_wb_b[0]),
    .out_valid(o_out_valid[0]), .out_addr(o_out_addr[0]),
    .busy(o_busy[0]), .done(o_done[0]), .o_dbg_state(o_dbg[0])
  );

  fft_bf_scheduler #(.LOG2N(LOG2N), .BF_LAT(4)) dut1 (
    .clock(clock), .n_rst(n_rst), .readyin(readyin),
    .wr_en(o_wr_en[1]), .wr_addr(o_wr_addr[1]),
    .bf_valid(o_bf_valid[1]), .rd_a(o_rd_a[1]), .rd_b(o_rd_b[1]), .tw_idx(o_tw[1]),
    .wb_en(o_wb_en[1]), .wb_a(o_wb_a[1]), .wb_b(o_wb_b[1]),
    .out_valid(o_out_valid[1]), .out_addr(o_out_addr[1]),
    .busy(o_busy[1]), .done(o_done[1]), .o_dbg_state(o_dbg[1])
  );

  // ---------------- model state ----------------
  int   lat   [2];
  int   m_ph  [2];
  int   m_cnt [2];
  int   m_t   [2];
  bit   m_r0  [2];
  bit   m_r1  [2];
  int   tab_a [LOG2N][HN];
  int   tab_b [LOG2N][HN];
  int   tab_tw[LOG2N][HN];
  int   n_chk, n_pass, cyc;

  // ---------------- scoreboard / observation ----------------
  logic [LOG2N-1:0] exp_q[$];
  int   cap_wr[$];
  int   cap_out[$];
  int   cnt_busy[2];
  int   cnt_done[2];
  int   cnt_wr0, cnt_wb0;
  logic [7:0] seen[2];

  int lit_br [8]    = '{0, 4, 2, 6, 1, 5, 3, 7};
  int lit_a  [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
  int lit_b  [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
  int lit_tw [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

  function automatic int brev(int x);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  // Butterfly list per stage: walk groups, then positions inside each group.
  task automatic build_tables();
    for (int s = 0; s < LOG2N; s++) begin
      int half = 1 << s;
      int idx  = 0;
      for (int g = 0; g < N / (2 * half); g++) begin
        for (int p = 0; p < half; p++) begin
          tab_a[s][idx]  = g * 2 * half + p;
          tab_b[s][idx]  = g * 2 * half + p + half;
          tab_tw[s][idx] = p * (N / (2 * half));
          idx++;
        end
      end
    end
  endtask

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, got, exp);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int e_we, e_wa, e_bv, e_ra, e_rb, e_tw, e_wb, e_wba, e_wbb, e_ov, e_oa, e_busy, e_done;
      int seg, t2;
      bit ev;
      e_we = 0; e_wa = 0; e_bv = 0; e_ra = 0; e_rb = 0; e_tw = 0; e_wb = 0;
      e_wba = 0; e_wbb = 0; e_ov = 0; e_oa = 0; e_busy = 0; e_done = 0;
      seg = HN + lat[i];
      if (n_rst) begin
        ev = m_r0[i] && !m_r1[i];
        case (m_ph[i])
          P_LOAD: if (ev) begin e_we = 1; e_wa = brev(m_cnt[i]); end
          P_COMP: begin
            e_busy = 1;
            if (m_t[i] % seg < HN) begin
              e_bv = 1;
              e_ra = tab_a[m_t[i] / seg][m_t[i] % seg];
              e_rb = tab_b[m_t[i] / seg][m_t[i] % seg];
              e_tw = tab_tw[m_t[i] / seg][m_t[i] % seg];
            end
            t2 = m_t[i] - lat[i];
            if (t2 >= 0 && (t2 % seg) < HN) begin
              e_wb = 1;
              e_wba = tab_a[t2 / seg][t2 % seg];
              e_wbb = tab_b[t2 / seg][t2 % seg];
            end
          end
          P_UNLOAD: if (ev) begin e_ov = 1; e_oa = m_cnt[i]; end
          P_DONE: e_done = 1;
          default: ;
        endcase
      end
      chk($sformatf("i%0d.wr_en", i),     int'(o_wr_en[i]),     e_we);
      chk($sformatf("i%0d.wr_addr", i),   int'(o_wr_addr[i]),   e_wa);
      chk($sformatf("i%0d.bf_valid", i),  int'(o_bf_valid[i]),  e_bv);
      chk($sformatf("i%0d.rd_a", i),      int'(o_rd_a[i]),      e_ra);
      chk($sformatf("i%0d.rd_b", i),      int'(o_rd_b[i]),      e_rb);
      chk($sformatf("i%0d.tw_idx", i),    int'(o_tw[i]),        e_tw);
      chk($sformatf("i%0d.wb_en", i),     int'(o_wb_en[i]),     e_wb);
      chk($sformatf("i%0d.wb_a", i),      int'(o_wb_a[i]),      e_wba);
      chk($sformatf("i%0d.wb_b", i),      int'(o_wb_b[i]),      e_wbb);
      chk($sformatf("i%0d.out_valid", i), int'(o_out_valid[i]), e_ov);
      chk($sformatf("i%0d.out_addr", i),  int'(o_out_addr[i]),  e_oa);
      chk($sformatf("i%0d.busy", i),      int'(o_busy[i]),      e_busy);
      chk($sformatf("i%0d.done", i),      int'(o_done[i]),      e_done);
      seen[i][o_dbg[i]] = 1'b1;
      if (o_busy[i]) cnt_busy[i]++;
      if (o_done[i]) cnt_done[i]++;
    end
    if (o_wr_en[0]) begin cap_wr.push_back(int'(o_wr_addr[0])); cnt_wr0++; end
    if (o_out_valid[0]) cap_out.push_back(int'(o_out_addr[0]));
    if (o_wb_en[0]) cnt_wb0++;
  endtask

  // Phase-level model: counts accepted strobes and elapsed compute cycles.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit ev;
      if (!n_rst) begin
        m_ph[i] = P_IDLE; m_cnt[i] = 0; m_t[i] = 0; m_r0[i] = 0; m_r1[i] = 0;
      end else begin
        ev = m_r0[i] && !m_r1[i];
        case (m_ph[i])
          P_IDLE: begin m_ph[i] = P_LOAD; m_cnt[i] = 0; end
          P_LOAD: if (ev) begin
            m_cnt[i]++;
            if (m_cnt[i] == N) begin m_ph[i] = P_COMP; m_t[i] = 0; m_cnt[i] = 0; end
          end
          P_COMP: begin
            m_t[i]++;
            if (m_t[i] == LOG2N * (HN + lat[i])) begin m_ph[i] = P_UNLOAD; m_cnt[i] = 0; end
          end
          P_UNLOAD: if (ev) begin
            m_cnt[i]++;
            if (m_cnt[i] == N) begin m_ph[i] = P_DONE; m_cnt[i] = 0; end
          end
          default: m_ph[i] = P_IDLE;
        endcase
        m_r1[i] = m_r0[i];
        m_r0[i] = readyin;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clock);
      compare_all();
      @(posedge clock);
      model_step();
      cyc++;
      #1;
    end
  endtask

  task automatic pulse(int hi, int lo);
    readyin = 1'b1;
    tick(hi);
    readyin = 1'b0;
    tick(lo);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int q_wr, q_out, b0, b1, d0, d1, w0, wb0;
    bit hit;
    lat[0] = 2; lat[1] = 4;
    n_chk = 0; n_pass = 0; cyc = 0; cnt_wr0 = 0; cnt_wb0 = 0;
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = P_IDLE; m_cnt[i] = 0; m_t[i] = 0; m_r0[i] = 0; m_r1[i] = 0;
      cnt_busy[i] = 0; cnt_done[i] = 0; seen[i] = '0;
    end
    build_tables();
    for (int k = 0; k < N; k++) chk("model.bitrev", brev(k), lit_br[k]);
    for (int s = 0; s < LOG2N; s++)
      for (int k = 0; k < HN; k++) begin
        chk($sformatf("model.s%0d.rd_a", s), tab_a[s][k], lit_a[s][k]);
        chk($sformatf("model.s%0d.rd_b", s), tab_b[s][k], lit_b[s][k]);
        chk($sformatf("model.s%0d.tw", s), tab_tw[s][k], lit_tw[s][k]);
      end

    // Frame 1: spaced loads, strobes toggled during compute, unload.
    tick(4);
    n_rst = 1'b1;
    b0 = cnt_busy[0]; b1 = cnt_busy[1]; d0 = cnt_done[0]; d1 = cnt_done[1];
    q_wr = cap_wr.size(); q_out = cap_out.size();
    tick(2);
    repeat (8) pulse(1, 3);
    repeat (14) begin readyin = ~readyin; tick(1); end
    tick(14);
    repeat (8) pulse(1, 2);
    tick(4);
    chk("f1.wr_count", cap_wr.size() - q_wr, 8);
    for (int k = 0; k < 8; k++)
      if (q_wr + k < cap_wr.size()) chk("f1.wr_addr", cap_wr[q_wr + k], lit_br[k]);
    chk("f1.out_count", cap_out.size() - q_out, 8);
    for (int k = 0; k < 8; k++)
      if (q_out + k < cap_out.size()) chk("f1.out_addr", cap_out[q_out + k], k);
    chk("f1.busy_lat2", cnt_busy[0] - b0, 18);
    chk("f1.busy_lat4", cnt_busy[1] - b1, 24);
    chk("f1.done_lat2", cnt_done[0] - d0, 1);
    chk("f1.done_lat4", cnt_done[1] - d1, 1);

    // Frame 2: first sample held high 20 cycles, rest at max rate.
    w0 = cnt_wr0;
    readyin = 1'b1;
    tick(20);
    readyin = 1'b0;
    tick(2);
    chk("held_high.wr_count", cnt_wr0 - w0, 1);
    repeat (7) pulse(1, 1);

    // Reset after two stage-1 issues of the BF_LAT=2 instance.
    hit = 1'b0;
    for (int g = 0; g < 100 && !hit; g++) begin
      if (m_ph[0] == P_COMP && m_t[0] == HN + lat[0] + 2) hit = 1'b1;
      else tick(1);
    end
    chk("mid_reset.reached", int'(hit), 1);
    n_rst = 1'b0;
    wb0 = cnt_wb0;
    tick(3);
    n_rst = 1'b1;
    tick(8);
    chk("mid_reset.wb_after", cnt_wb0 - wb0, 0);
    q_wr = cap_wr.size();
    repeat (8) pulse(1, 1);
    tick(2);
    chk("post_reset.wr_count", cap_wr.size() - q_wr, 8);
    for (int k = 0; k < 8; k++)
      if (q_wr + k < cap_wr.size()) chk("post_reset.wr_addr", cap_wr[q_wr + k], lit_br[k]);

    // Random strobes with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        n_rst = 1'b0;
        tick($urandom_range(1, 3));
        n_rst = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) readyin = ~readyin;
      tick(1);
    end
    readyin = 1'b0;
    tick(4);
    chk("states_seen_lat2", $countones(seen[0]), 6);
    chk("states_seen_lat4", $countones(seen[1]), 6);
    if (exp_q.size() != 0) exp_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
